// File: rtl/world_controller_if.sv
// Signal bundle between the game-flow controller and the rest of the game:
// frame/key/position/collision inputs and the world-select, freeze and
// status outputs.
//
// Handshake: there is no valid/ready pair on this bundle. frame_tick and
// start are single-cycle strobes that are acted on in the cycle they are
// high. hit_hazard and the position/exit buses are levels sampled on
// frame_tick cycles. world_load and player_respawn are single-cycle
// strobes. All other outputs are registered levels.
interface world_controller_if;
  logic             frame_tick;
  logic             start;
  logic [9:0]       player_x;
  logic [9:0]       player_y;
  logic [1:0][9:0]  info_exit;
  logic             hit_hazard;
  logic [1:0]       selector_value;
  logic             world_load;
  logic             player_respawn;
  logic             freeze;
  logic [1:0]       lives;
  logic             game_over;
  logic             game_won;
  logic [2:0]       state_dbg;

  // Drives the game inputs and observes the controller.
  modport master (
    output frame_tick, start, player_x, player_y, info_exit, hit_hazard,
    input  selector_value, world_load, player_respawn, freeze, lives,
           game_over, game_won, state_dbg
  );

  // The controller itself.
  modport slave (
    input  frame_tick, start, player_x, player_y, info_exit, hit_hazard,
    output selector_value, world_load, player_respawn, freeze, lives,
           game_over, game_won, state_dbg
  );
endinterface

// File: rtl/world_controller.sv
// Game-flow controller: sequences load, play, death, level-clear, game-over
// and win phases, selects the active world and keeps the life count.
// Every output is a flop. Each output's next value is derived from the next
// state, so the outputs line up with state_dbg in the same cycle.
module world_controller #(
  parameter int NUM_WORLDS       = 2,
  parameter int LIVES_INIT       = 3,
  parameter int EXIT_TOL         = 8,
  parameter int EXIT_HOLD_FRAMES = 4,
  parameter int DEATH_FRAMES     = 60,
  parameter int CLEAR_FRAMES     = 90
) (
  input  logic                Clk,
  input  logic                Reset,
  world_controller_if.slave   bus
);

  localparam int FRAME_MAX = (DEATH_FRAMES > CLEAR_FRAMES) ? DEATH_FRAMES : CLEAR_FRAMES;
  localparam int HOLD_W    = $clog2(EXIT_HOLD_FRAMES + 1);
  localparam int FRAME_W   = $clog2(FRAME_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_PLAY  = 3'd2,
    S_DYING = 3'd3,
    S_CLEAR = 3'd4,
    S_OVER  = 3'd5,
    S_WON   = 3'd6
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          sel_q, sel_d;
  logic [1:0]          lives_q, lives_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [FRAME_W-1:0]  frame_q, frame_d;
  logic                world_load_q, world_load_d;
  logic                respawn_q, respawn_d;
  logic                freeze_q, freeze_d;
  logic                over_q, over_d;
  logic                won_q, won_d;

  logic [9:0]          dx, dy;
  logic                in_exit;
  logic [HOLD_W-1:0]   hold_inc;
  logic [FRAME_W-1:0]  frame_inc;

  // Exit hit test: per-axis distance taken as larger minus smaller, so no wrap.
  always_comb begin
    dx        = (bus.player_x >= bus.info_exit[0]) ? (bus.player_x - bus.info_exit[0])
                                                   : (bus.info_exit[0] - bus.player_x);
    dy        = (bus.player_y >= bus.info_exit[1]) ? (bus.player_y - bus.info_exit[1])
                                                   : (bus.info_exit[1] - bus.player_y);
    in_exit   = (dx < 10'(EXIT_TOL)) && (dy < 10'(EXIT_TOL));
    hold_inc  = hold_q + HOLD_W'(1);
    frame_inc = frame_q + FRAME_W'(1);
  end

  // Next-state, world/lives bookkeeping and registered-output preparation.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    lives_d = lives_q;
    hold_d  = hold_q;
    frame_d = frame_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_LOAD;
          sel_d   = 2'd0;
          lives_d = 2'(LIVES_INIT);
        end
      end
      S_LOAD: begin
        state_d = S_PLAY;
        hold_d  = '0;
      end
      S_PLAY: begin
        if (bus.frame_tick) begin
          if (bus.hit_hazard) begin
            state_d = S_DYING;
          end else if (in_exit) begin
            if (hold_inc == HOLD_W'(EXIT_HOLD_FRAMES)) state_d = S_CLEAR;
            else                                       hold_d  = hold_inc;
          end else begin
            hold_d = '0;
          end
        end
      end
      S_DYING: begin
        if (bus.frame_tick) begin
          if (frame_inc == FRAME_W'(DEATH_FRAMES)) begin
            if (lives_q == 2'd1) begin
              state_d = S_OVER;
              lives_d = 2'd0;
            end else begin
              state_d = S_LOAD;
              lives_d = lives_q - 2'd1;
            end
          end else begin
            frame_d = frame_inc;
          end
        end
      end
      S_CLEAR: begin
        if (bus.frame_tick) begin
          if (frame_inc == FRAME_W'(CLEAR_FRAMES)) begin
            if (sel_q == 2'(NUM_WORLDS - 1)) begin
              state_d = S_WON;
            end else begin
              state_d = S_LOAD;
              sel_d   = sel_q + 2'd1;
            end
          end else begin
            frame_d = frame_inc;
          end
        end
      end
      S_OVER, S_WON: begin
        if (bus.start) begin
          state_d = S_LOAD;
          sel_d   = 2'd0;
          lives_d = 2'(LIVES_INIT);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Every state entry starts its counters from zero.
    if (state_d != state_q) begin
      hold_d  = '0;
      frame_d = '0;
    end

    world_load_d = (state_d == S_LOAD);
    respawn_d    = (state_d == S_LOAD);
    freeze_d     = (state_d != S_PLAY);
    over_d       = (state_d == S_OVER);
    won_d        = (state_d == S_WON);
  end

  // State, counters and output registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q      <= S_IDLE;
      sel_q        <= 2'd0;
      lives_q      <= 2'(LIVES_INIT);
      hold_q       <= '0;
      frame_q      <= '0;
      world_load_q <= 1'b0;
      respawn_q    <= 1'b0;
      freeze_q     <= 1'b1;
      over_q       <= 1'b0;
      won_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      lives_q      <= lives_d;
      hold_q       <= hold_d;
      frame_q      <= frame_d;
      world_load_q <= world_load_d;
      respawn_q    <= respawn_d;
      freeze_q     <= freeze_d;
      over_q       <= over_d;
      won_q        <= won_d;
    end
  end

  assign bus.selector_value = sel_q;
  assign bus.lives          = lives_q;
  assign bus.world_load     = world_load_q;
  assign bus.player_respawn = respawn_q;
  assign bus.freeze         = freeze_q;
  assign bus.game_over      = over_q;
  assign bus.game_won       = won_q;
  assign bus.state_dbg      = state_q;

endmodule
